cic_comp_fir: RTL and testbench

- Downstream of the 31-bit CIC decimator. Consumes its output word and its output-rate clock level, and applies a 15-tap symmetric FIR droop-compensation filter.
- Runs on the fast system clock. Uses one time-shared multiplier: the tap-pair folding gives 8 MAC cycles per output sample.
- Produces a rounded, narrowed sample with a one-cycle valid pulse for the next stage (half-band decimator or output formatter).

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_comp_mac.sv | 31 +++
 rtl/cic_comp_fir.sv | 100 ++++++++++
 tb/tb_cic_comp_fir.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: shared constants, coefficients and FSM state type for the CIC compensation FIR
package cic_pkg;
  localparam int DEF_IN_W = 31;
  localparam int DEF_COEF_W = 18;
  localparam int DEF_ACC_W = 56;
  localparam int DEF_OUT_SHIFT = 22;
  localparam int DEF_OUT_W = 24;
  localparam int NTAPS = 15;
  localparam int NMAC = 8;
  localparam logic signed [DEF_COEF_W-1:0] COEF [NMAC] = '{
    -18'sd48, 18'sd96, -18'sd200, 18'sd380, -18'sd700, 18'sd1400, -18'sd3200, 18'sd37312
  };
  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;
endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: symmetric-tap pre-adder, multiplier and accumulator with clear/enable
module cic_comp_mac #(
  parameter int IN_W = 31,
  parameter int COEF_W = 18,
  parameter int ACC_W = 56
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [IN_W-1:0]   a,
  input  logic signed [IN_W-1:0]   b,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);
  localparam int PW = IN_W + 1 + COEF_W;
  logic signed [IN_W:0] pre;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  // pre-add the mirrored taps, multiply, and accumulate
  always_comb begin
    pre = {a[IN_W-1], a} + {b[IN_W-1], b};
    prod = pre * coef;
    acc_d = clr ? '0 : en ? acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod} : acc_q;
  end
  // accumulator register
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: 15-tap symmetric droop-compensation FIR after the CIC; CIC_COMP_SAT_EN enables output saturation
module cic_comp_fir
  import cic_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_strobe,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);
  fir_state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic signed [IN_W-1:0] x_q [NTAPS];
  logic signed [IN_W-1:0] x_d [NTAPS];
  logic strobe_prev_q, overrun_q, overrun_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic edge_det, mac_clr, mac_en;
  logic signed [IN_W-1:0] tap_a, tap_b;
  logic signed [ACC_W-1:0] acc, rnd, r;
  logic [OUT_W-1:0] narrow;
  assign edge_det = in_strobe & ~strobe_prev_q;
  assign tap_a = x_q[{1'b0, k_q}];
  // the centre tap has no mirror partner, so its pre-add partner is zero
  assign tap_b = (k_q == 3'd7) ? '0 : x_q[4'(NTAPS - 1) - {1'b0, k_q}];
  cic_comp_mac #(.IN_W(IN_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en),
    .a(tap_a), .b(tap_b), .coef(COEF_W'(COEF[k_q])), .acc(acc)
  );
  // round half up, then shift down to output scale
  always_comb begin
    rnd = acc + (ACC_W'(1) << (OUT_SHIFT - 1));
    r = rnd >>> OUT_SHIFT;
  end
`ifdef CIC_COMP_SAT_EN
  localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;
  // clamp to the signed output range
  always_comb narrow = (r > R_MAX) ? R_MAX[OUT_W-1:0] : (r < R_MIN) ? R_MIN[OUT_W-1:0] : r[OUT_W-1:0];
`else
  // two's-complement wrap to the output width
  always_comb narrow = r[OUT_W-1:0];
`endif
  // sequencing: capture, 8 MAC cycles, round, output pulse; edges outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    x_d = x_q;
    out_data_d = out_data_q;
    overrun_d = overrun_q | (edge_det & (state_q != IDLE));
    mac_clr = 1'b0;
    mac_en = 1'b0;
    case (state_q)
      IDLE: if (edge_det) begin
        x_d[0] = in_data;
        for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
        mac_clr = 1'b1;
        k_d = '0;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        k_d = k_q + 3'd1;
        state_d = (k_q == 3'(NMAC - 1)) ? ROUND : MAC;
      end
      ROUND: begin
        out_data_d = narrow;
        state_d = OUT;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, delay line and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      x_q <= '{default: '0};
      strobe_prev_q <= 1'b1;
      overrun_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      x_q <= x_d;
      strobe_prev_q <= in_strobe;
      overrun_q <= overrun_d;
      out_data_q <= out_data_d;
    end
  assign out_data = out_data_q;
  assign out_valid = (state_q == OUT);
  assign overrun = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: table-driven directed checks of the CIC compensation FIR
module tb_cic_comp_fir;
  logic clk = 0, rst = 1, in_strobe = 1, out_valid, overrun;
  logic [30:0] in_data = '0;
  logic [23:0] out_data;
  int checks = 0, errors = 0;
  typedef struct {
    logic [30:0] din;
    longint dout;
    bit chk;
  } vec_t;
  vec_t tv[$];
  longint hv [15] = '{-48, 96, -200, 380, -700, 1400, -3200, 37312, -3200, 1400, -700, 380, -200, 96, -48};

  cic_comp_fir dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe),
    .out_data(out_data), .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [30:0] d, output longint got, output int lat, output int pulses);
    got = 0; lat = -1; pulses = 0;
    @(negedge clk);
    in_data = d;
    in_strobe = 1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 3) in_strobe = 0;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          got = longint'($signed(out_data));
        end
      end
    end
  endtask

  task automatic run_tv(input string nm);
    longint got;
    int lat, pulses;
    foreach (tv[i]) begin
      send(tv[i].din, got, lat, pulses);
      if (tv[i].chk) begin
        chk($sformatf("%s[%0d] data", nm, i), got, tv[i].dout);
        chk($sformatf("%s[%0d] latency", nm, i), lat, 10);
        chk($sformatf("%s[%0d] pulses", nm, i), pulses, 1);
      end
    end
  endtask

  task automatic load_impulse();
    tv.delete();
    for (int i = 0; i < 16; i++) tv.push_back('{(i == 0) ? 31'd4194304 : 31'd0, (i < 15) ? hv[i] : 0, 1'b1});
  endtask

  task automatic load_const(input logic [30:0] d, input longint exp);
    tv.delete();
    for (int i = 0; i < 20; i++) tv.push_back('{d, exp, i >= 14});
  endtask

  initial begin
    longint got, ov_exp;
    int lat, pulses;
    // reset held with strobe high; release must not look like an edge
    in_data = 31'd777;
    repeat (3) @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("reset no_capture", pulses, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset overrun", overrun, 0);
    @(negedge clk);
    in_strobe = 0;
    load_impulse();
    run_tv("impulse");
    load_const(31'd1048576, 8192);
    run_tv("dc");
`ifdef CIC_COMP_SAT_EN
    ov_exp = 8388607;
`else
    ov_exp = -8388608;
`endif
    load_const(31'd1073741823, ov_exp);
    run_tv("overflow");
    // reset in cycle 4 after a capture edge
    @(negedge clk);
    in_data = 31'd12345;
    in_strobe = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) in_strobe = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("midmac no_valid", pulses, 0);
    chk("midmac out_data", out_data, 0);
    load_impulse();
    run_tv("post_reset_impulse");
    chk("overrun before", overrun, 0);
    // second edge arrives during MAC and must be dropped
    @(negedge clk);
    in_data = 31'd4194304;
    in_strobe = 1;
    pulses = 0;
    got = 0;
    lat = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 2 || c == 8) in_strobe = 0;
      if (c == 6) begin
        in_data = 31'd16777216;
        in_strobe = 1;
      end
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          got = longint'($signed(out_data));
        end
      end
    end
    chk("overrun pulses", pulses, 1);
    chk("overrun data", got, -48);
    chk("overrun latency", lat, 10);
    chk("overrun flag", overrun, 1);
    send(31'd0, got, lat, pulses);
    chk("overrun dropped_sample", got, 96);
    chk("overrun sticky", overrun, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
